// File: rtl/sdpramb_sclk_init_if.sv
// ============================================================================
// Module      : sdpramb_sclk_init_if
// Description : Write/read/status bundle of the single-clock SDP block RAM.
//               Optional SDPRAMB_SCLK_PARITY_EN adds the par_err lane flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sdpramb_sclk_init_if #(
   parameter int WIDTH     = 32,
   parameter int DEPTHBIT  = 10,
   parameter int CNT_WIDTH = 16
);
`ifdef SDPRAMB_SCLK_PARITY_EN
   localparam int PW = (WIDTH + 7) / 8;
`endif

   logic                 wren;
   logic [DEPTHBIT-1:0]  wraddress;
   logic [WIDTH-1:0]     data;
   logic                 rden;
   logic [DEPTHBIT-1:0]  rdaddress;
   logic [WIDTH-1:0]     q;
   logic                 q_vld;
   logic                 init_done;
   logic [CNT_WIDTH-1:0] coll_cnt;
   logic                 coll_cnt_clr;
`ifdef SDPRAMB_SCLK_PARITY_EN
   logic [PW-1:0]        par_err;
`endif

   modport master (
      output wren, wraddress, data, rden, rdaddress, coll_cnt_clr,
      input  q, q_vld, init_done, coll_cnt
`ifdef SDPRAMB_SCLK_PARITY_EN
      , input par_err
`endif
   );

   modport slave (
      input  wren, wraddress, data, rden, rdaddress, coll_cnt_clr,
      output q, q_vld, init_done, coll_cnt
`ifdef SDPRAMB_SCLK_PARITY_EN
      , output par_err
`endif
   );

endinterface

`default_nettype wire

// File: rtl/sdpramb_sclk_init.sv
// ============================================================================
// Module      : sdpramb_sclk_init
// Description : Single-clock simple dual-port RAM with post-reset clear,
//               read-valid tracking, write-first bypass and a saturating
//               collision counter. Macro SDPRAMB_SCLK_PARITY_EN adds per-byte
//               even parity storage and par_err reporting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdpramb_sclk_init #(
   parameter int WIDTH       = 32,
   parameter int DEPTHBIT    = 10,
   parameter int RAM_OUT_REG = 1,
   parameter int INIT_CLEAR  = 1,
   parameter int CNT_WIDTH   = 16
) (
   input  wire logic          clks,
   input  wire logic          reset,
   sdpramb_sclk_init_if.slave bus
);

   localparam int DEPTH = 1 << DEPTHBIT;
`ifdef SDPRAMB_SCLK_PARITY_EN
   localparam int PW = (WIDTH + 7) / 8;
   localparam int MW = WIDTH + PW;

   function automatic logic [PW-1:0] lane_par(input logic [WIDTH-1:0] d);
      logic [PW-1:0] p;
      p = '0;
      for (int i = 0; i < WIDTH; i++) p[i/8] = p[i/8] ^ d[i];
      return p;
   endfunction
`else
   localparam int MW = WIDTH;
`endif

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam state_t RST_STATE = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;

   state_t               state_q, state_d;
   logic [DEPTHBIT-1:0]  ptr_q, ptr_d;
   logic                 init_done_q, init_done_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [MW-1:0]        mem_q [DEPTH];
   logic                 s1_vld_q;
   logic [MW-1:0]        s1_dat_q;

   logic                 w_run, w_coll, w_rd_fire, w_we;
   logic [DEPTHBIT-1:0]  w_wa;
   logic [MW-1:0]        w_wd, w_wr_word, w_rd_word;

`ifdef SDPRAMB_SCLK_PARITY_EN
   logic [PW-1:0]        w_s1_err;
   assign w_wr_word = {lane_par(bus.data), bus.data};
   assign w_s1_err  = s1_dat_q[MW-1:WIDTH] ^ lane_par(s1_dat_q[WIDTH-1:0]);
`else
   assign w_wr_word = bus.data;
`endif

   assign w_run     = (state_q == ST_RUN);
   assign w_coll    = w_run && bus.wren && bus.rden && (bus.wraddress == bus.rdaddress);
   assign w_rd_fire = w_run && bus.rden;
   // Write-first: a same-cycle write to the read address wins over the array.
   assign w_rd_word = w_coll ? w_wr_word : mem_q[bus.rdaddress];

   always_ff @(posedge clks or posedge reset) begin
      if (reset) begin
         state_q     <= RST_STATE;
         ptr_q       <= '0;
         init_done_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         init_done_q <= init_done_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      init_done_d = init_done_q;
      w_we        = 1'b0;
      w_wa        = bus.wraddress;
      w_wd        = w_wr_word;
      case (state_q)
         ST_INIT: begin
            w_we  = 1'b1;
            w_wa  = ptr_q;
            w_wd  = '0;
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == '1) begin
               state_d     = ST_RUN;
               init_done_d = 1'b1;
            end
         end
         default: begin
            w_we        = bus.wren;
            init_done_d = 1'b1;
         end
      endcase
   end

   // Clear wins over a same-cycle increment; the count sticks at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (bus.coll_cnt_clr)
         cnt_d = '0;
      else if (w_coll && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clks) begin
      if (w_we) mem_q[w_wa] <= w_wd;
   end

   always_ff @(posedge clks or posedge reset) begin
      if (reset) begin
         s1_vld_q <= 1'b0;
         s1_dat_q <= '0;
      end else begin
         s1_vld_q <= w_rd_fire;
         if (w_rd_fire) s1_dat_q <= w_rd_word;
      end
   end

   generate
      if (RAM_OUT_REG != 0) begin : g_out_reg
         logic [WIDTH-1:0] q_q;
         logic             vld_q;
`ifdef SDPRAMB_SCLK_PARITY_EN
         logic [PW-1:0]    perr_q;
         always_ff @(posedge clks or posedge reset) begin
            if (reset)
               perr_q <= '0;
            else
               perr_q <= s1_vld_q ? w_s1_err : '0;
         end
         assign bus.par_err = perr_q;
`endif
         always_ff @(posedge clks or posedge reset) begin
            if (reset) begin
               vld_q <= 1'b0;
               q_q   <= '0;
            end else begin
               vld_q <= s1_vld_q;
               if (s1_vld_q) q_q <= s1_dat_q[WIDTH-1:0];
            end
         end
         assign bus.q     = q_q;
         assign bus.q_vld = vld_q;
      end else begin : g_out_direct
`ifdef SDPRAMB_SCLK_PARITY_EN
         assign bus.par_err = s1_vld_q ? w_s1_err : '0;
`endif
         assign bus.q     = s1_dat_q[WIDTH-1:0];
         assign bus.q_vld = s1_vld_q;
      end
   endgenerate

   assign bus.init_done = init_done_q;
   assign bus.coll_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sdpramb_sclk_init.sv
// ============================================================================
// Module      : tb_sdpramb_sclk_init
// Description : Directed bench; dutA has latency 2 and a 4-bit counter,
//               dutB latency 1 and a 16-bit counter, both fed the same vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdpramb_sclk_init;

   logic        clk;
   logic        rst;
   logic        wren, rden, clr;
   logic [3:0]  wa, ra;
   logic [31:0] wd;

   int n_tests = 0;
   int n_fail  = 0;

   sdpramb_sclk_init_if #(.WIDTH(32), .DEPTHBIT(4), .CNT_WIDTH(4))  ifA ();
   sdpramb_sclk_init_if #(.WIDTH(32), .DEPTHBIT(4), .CNT_WIDTH(16)) ifB ();

   assign ifA.wren = wren;  assign ifA.wraddress = wa;  assign ifA.data = wd;
   assign ifA.rden = rden;  assign ifA.rdaddress = ra;  assign ifA.coll_cnt_clr = clr;
   assign ifB.wren = wren;  assign ifB.wraddress = wa;  assign ifB.data = wd;
   assign ifB.rden = rden;  assign ifB.rdaddress = ra;  assign ifB.coll_cnt_clr = clr;

   sdpramb_sclk_init #(.WIDTH(32), .DEPTHBIT(4), .RAM_OUT_REG(1), .INIT_CLEAR(1), .CNT_WIDTH(4))
      dutA (.clks(clk), .reset(rst), .bus(ifA));
   sdpramb_sclk_init #(.WIDTH(32), .DEPTHBIT(4), .RAM_OUT_REG(0), .INIT_CLEAR(1), .CNT_WIDTH(16))
      dutB (.clks(clk), .reset(rst), .bus(ifB));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: array contents, run flag, and a two-deep history of
   // read results (index 0 = read accepted at the last edge).
   logic [31:0] m_mem [16];
   bit          m_flip [16];
   bit          m_run;
   int          m_init_left;
   int          m_cntA, m_cntB;
   bit          pv0, pv1, pe0, pe1;
   logic [31:0] pd0, pd1, eqA, eqB;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_mem[i]  = '0;
         m_flip[i] = 1'b0;
      end
      m_run = 1'b0; m_init_left = 16; m_cntA = 0; m_cntB = 0;
      pv0 = 0; pv1 = 0; pe0 = 0; pe1 = 0; pd0 = '0; pd1 = '0; eqA = '0; eqB = '0;
   endtask

   task automatic compare();
      chk("A.q_vld", ifA.q_vld, pv1);
      chk("B.q_vld", ifB.q_vld, pv0);
      chk("A.q", ifA.q, eqA);
      chk("B.q", ifB.q, eqB);
      chk("A.init_done", ifA.init_done, m_run);
      chk("B.init_done", ifB.init_done, m_run);
      chk("A.coll_cnt", ifA.coll_cnt, m_cntA);
      chk("B.coll_cnt", ifB.coll_cnt, m_cntB);
`ifdef SDPRAMB_SCLK_PARITY_EN
      chk("A.par_err", ifA.par_err, {3'b000, pe1});
      chk("B.par_err", ifB.par_err, 4'b0000);
`endif
   endtask

   task automatic step();
      bit          rv, re, coll;
      logic [31:0] rd;
      rv = m_run && rden;
      re = 1'b0; coll = 1'b0; rd = '0;
      if (m_run) begin
         coll = wren && rden && (wa == ra);
         rd   = coll ? wd : m_mem[ra];
         re   = rv && !coll && m_flip[ra];
         if (wren) begin
            m_mem[wa]  = wd;
            m_flip[wa] = 1'b0;
         end
      end
      if (clr) m_cntA = 0; else if (coll && m_cntA < 15) m_cntA++;
      if (clr) m_cntB = 0; else if (coll && m_cntB < 65535) m_cntB++;
      if (!m_run) begin
         m_init_left--;
         if (m_init_left == 0) m_run = 1'b1;
      end
      pv1 = pv0; pd1 = pd0; pe1 = pe0;
      pv0 = rv;  pd0 = rd;  pe0 = re;
      if (pv1) eqA = pd1;
      if (pv0) eqB = pd0;
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic idle();
      wren = 0; rden = 0; clr = 0;
   endtask

   initial begin
      int n;
      rst = 1'b1; idle(); wa = '0; ra = '0; wd = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      compare();

      // Init: user traffic is ignored until init_done.
      @(negedge clk);
      rst = 1'b0;
      wren = 1; wd = 32'hFFFF_FFFF; rden = 1;
      n = 0;
      while (!ifA.init_done && n < 40) begin
         wa = 4'(n); ra = 4'(n);
         step();
         n++;
      end
      chk("init_len", n, 16);
      idle();

      for (int a = 0; a < 16; a++) begin
         rden = 1; ra = 4'(a); step();
      end
      idle(); step(); step();
      chk("lit.clear_q", ifA.q, 32'h0);

      // Latency.
      wren = 1; wa = 4'd3; wd = 32'hA5A5_0001; step();
      wren = 0; rden = 1; ra = 4'd3; step();
      chk("lit.B_t1_vld", ifB.q_vld, 1'b1);
      chk("lit.B_t1_q", ifB.q, 32'hA5A5_0001);
      chk("lit.A_t1_vld", ifA.q_vld, 1'b0);
      idle(); step();
      chk("lit.A_t2_vld", ifA.q_vld, 1'b1);
      chk("lit.A_t2_q", ifA.q, 32'hA5A5_0001);
      chk("lit.B_t2_vld", ifB.q_vld, 1'b0);
      step();

      // Collisions.
      wren = 1; wa = 4'd7; wd = 32'h11; step();
      rden = 1; ra = 4'd7; wd = 32'h22; step();
      chk("lit.coll_q", ifB.q, 32'h22);
      chk("lit.coll_cnt", ifA.coll_cnt, 4'd1);
      wa = 4'd8; wd = 32'h33; step();
      chk("lit.nocoll_q", ifB.q, 32'h22);
      chk("lit.nocoll_cnt", ifB.coll_cnt, 16'd1);
      idle(); step(); step();

      // Streaming.
      for (int a = 0; a < 16; a++) begin
         wren = 1; wa = 4'(a); wd = 32'(a); step();
      end
      wren = 0;
      for (int a = 0; a < 16; a++) begin
         rden = 1; ra = 4'(a); step();
      end
      idle(); step();
      chk("lit.stream_last", ifA.q, 32'd15);
      step();

      // Saturation and clear priority.
      for (int i = 0; i < 20; i++) begin
         wren = 1; rden = 1; wa = 4'd2; ra = 4'd2; wd = 32'(100 + i); step();
      end
      chk("lit.sat_A", ifA.coll_cnt, 4'd15);
      chk("lit.sat_B", ifB.coll_cnt, 16'd21);
      clr = 1; step();
      chk("lit.clr_A", ifA.coll_cnt, 4'd0);
      chk("lit.clr_B", ifB.coll_cnt, 16'd0);
      idle(); step(); step();

`ifdef SDPRAMB_SCLK_PARITY_EN
      dutA.mem_q[6][32] = ~dutA.mem_q[6][32];
      m_flip[6] = 1'b1;
      rden = 1; ra = 4'd6; step();
      idle(); step();
      chk("lit.par_err", ifA.par_err, 4'b0001);
      step();
`endif

      // Reset with two reads in flight.
      wren = 1; wa = 4'd5; wd = 32'hCAFE_F00D; step();
      wren = 0; rden = 1; ra = 4'd5; step();
      ra = 4'd3; step();
      idle();
      rst = 1'b1;
      #1;
      model_reset();
      compare();
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (!ifA.init_done && n < 40) begin
         step();
         n++;
      end
      chk("reinit_len", n, 16);
      rden = 1; ra = 4'd5; step();
      ra = 4'd3; step();
      idle(); step();
      chk("lit.reinit_q5", ifA.q, 32'h0);
      step(); step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sdpramb_sclk_init.md
Name: sdpramb_sclk_init

Overview:
- Single-clock simple dual-port block RAM for one write port and one read port. Successor to the dual-clock SDP RAM wrapper.
- Adds the following over the older block:
  - hardware clear of the whole array after reset
  - read-data valid tracking
  - write-first bypass on same-address collisions
  - a saturating collision counter
- Used for per-flow context tables and descriptor stores in the shell/user logic datapath, where the RAM must contain zeros before the first use.

Parameters:
- WIDTH, 32, data width in bits; must be 1..512.
- DEPTHBIT, 10, address width; depth is 2^DEPTHBIT.
- RAM_OUT_REG, 1, 0 = read latency 1 cycle, 1 = extra output register (latency 2).
- INIT_CLEAR, 1, 1 = zero the array after reset, 0 = skip directly to RUN.
- CNT_WIDTH, 16, width of the collision counter.

Ports:
- clks, input, 1, system clock; all logic is on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- wren, input, 1, write enable.
- wraddress, input, DEPTHBIT, write address.
- data, input, WIDTH, write data.
- rden, input, 1, read request.
- rdaddress, input, DEPTHBIT, read address.
- q, output, WIDTH, read data.
- q_vld, output, 1, one-cycle strobe: q is valid.
- init_done, output, 1, high once the array is usable.
- coll_cnt, output, CNT_WIDTH, saturating count of same-address read/write cycles.
- coll_cnt_clr, input, 1, synchronous clear of coll_cnt.

Behaviour:
- Reset (asynchronous, active-high): q=0, q_vld=0, init_done=0, coll_cnt=0, init pointer=0, all pipeline valids=0. FSM goes to INIT if INIT_CLEAR=1, otherwise to RUN.
- FSM INIT:
  - Each cycle writes 0 to the address held in the init pointer, then increments the pointer.
  - After address 2^DEPTHBIT-1 is written, moves to RUN on the next edge and sets init_done=1; init takes exactly 2^DEPTHBIT cycles.
  - User wren and rden are ignored; no q_vld is produced and coll_cnt does not count.
- FSM RUN:
  - wren=1 writes data to wraddress.
  - rden=1 at edge t gives q_vld=1 at edge t+1+RAM_OUT_REG, with q = contents of rdaddress.
  - Back-to-back reads are fully pipelined, one result per cycle.
- Write-first collision: if wren and rden are both 1 with wraddress==rdaddress in the same cycle:
  - the read returns the new data, not the old contents;
  - coll_cnt increments by 1.
  - Writes to an address in any earlier cycle are always visible to later reads.
- coll_cnt:
  - Saturates at all-ones and does not wrap.
  - coll_cnt_clr takes priority over a same-cycle increment; the result is 0.
- q holds its last valid value while q_vld=0.
- Addresses are taken modulo 2^DEPTHBIT; there are no out-of-range conditions.
- Reset asserted mid-operation:
  - In-flight reads are discarded (q_vld forced to 0) and init_done drops.
  - INIT restarts from address 0; array contents are cleared again when INIT_CLEAR=1.
- No combinational path from any input to any output.

Optional Feature:
- Macro SDPRAMB_SCLK_PARITY_EN.
- When defined:
  - The array stores one even-parity bit per 8-bit data lane (ceil(WIDTH/8) extra bits), computed at write time; INIT writes parity 0 (zero data has even parity).
  - On each read the parity is recomputed and compared.
  - Extra output port par_err [ceil(WIDTH/8)] is aligned with q_vld: the bit for a lane is 1 on mismatch, and all bits are 0 when q_vld=0.
  - A bypassed collision read uses the freshly computed parity, so it never flags an error.
- When not defined: no par_err port, no extra storage, and the behaviour is otherwise identical.

Test Plan:
- Init clear: WIDTH=32, DEPTHBIT=4; release reset → init_done rises exactly 16 cycles later. Read all 16 addresses → q=0 with q_vld each time. Reads issued during init → no q_vld.
- Latency: RAM_OUT_REG=1; write 0xA5A5_0001 to address 3, then rden to address 3 at cycle t → q_vld=1 and q=0xA5A5_0001 at t+2 only. Repeat with RAM_OUT_REG=0 → result at t+1.
- Collision:
  - Address 7 holds 0x11; in one cycle write 0x22 to address 7 and read address 7 → q=0x22 and coll_cnt=1.
  - Same-cycle write to address 8 while reading address 7 → q returns address 7's contents and coll_cnt does not change.
- Streaming: 16 back-to-back reads of addresses 0..15 after writing value=address → 16 consecutive q_vld pulses with q=0..15 in order.
- Counter: CNT_WIDTH=4; 20 collisions → coll_cnt=15 (saturated). coll_cnt_clr asserted together with a collision → coll_cnt=0.
- Reset mid-run: assert reset while 2 reads are in flight → q_vld stays 0, init_done=0, INIT reruns, and previously written data reads back as 0. With the parity macro defined, force a bit flip in the array → the matching par_err bit is 1 together with q_vld.
